// File: rtl/sensor_hub_controller.sv
// -----------------------------------------------------------------------------
// sensor_hub_controller
//   Host command handler for NUM_SENSORS DHT11-style 40-bit sensors. A host
//   request selects a channel via request_address and either answers at once
//   (errors, loop stop) or starts a sensor read and answers with the measured
//   value. Each channel can be put into continuous mode; looping channels are
//   polled round-robin, one poll per LOOP_PERIOD cycles.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   request_*           host command port (valid/ready, command, address)
//   sensor_enable       one-hot read strobe, held until the frame arrives
//   sensor_data         channel i frame in bits [40*i+39:40*i]
//   sensor_done/error   per-channel frame-received / protocol-error flags
//   response_*          response toward the UART (valid/ready, cmd, value, addr)
//   loop_active         per-channel continuous-mode flags
//
// Build option
//   SENSOR_TIMEOUT_EN   when defined, a read that sees no sensor_done within
//                       TIMEOUT_CYCLES cycles ends as a fault (1F/1F).
// -----------------------------------------------------------------------------
module sensor_hub_controller #(
  parameter int NUM_SENSORS = 4,
  parameter int LOOP_PERIOD = 100_000_000
`ifdef SENSOR_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 5_000_000
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      request_valid,
  output logic                      request_ready,
  input  logic [7:0]                request_command,
  input  logic [7:0]                request_address,
  output logic [NUM_SENSORS-1:0]    sensor_enable,
  input  logic [40*NUM_SENSORS-1:0] sensor_data,
  input  logic [NUM_SENSORS-1:0]    sensor_done,
  input  logic [NUM_SENSORS-1:0]    sensor_error,
  output logic                      response_valid,
  input  logic                      response_ready,
  output logic [7:0]                response_command,
  output logic [7:0]                response_value,
  output logic [7:0]                response_address,
  output logic [NUM_SENSORS-1:0]    loop_active
);

  localparam int CH_W  = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int TMR_W = (LOOP_PERIOD > 1) ? $clog2(LOOP_PERIOD) : 1;
  localparam logic [8:0] NUM_CH = 9'(NUM_SENSORS);

  localparam logic [7:0] CMD_CHECK = 8'hAC;
  localparam logic [7:0] CMD_TEMP  = 8'h01;
  localparam logic [7:0] CMD_HUM   = 8'h02;
  localparam logic [7:0] CMD_LOOPT = 8'h03;
  localparam logic [7:0] CMD_LOOPH = 8'h04;
  localparam logic [7:0] CMD_STOPT = 8'h05;
  localparam logic [7:0] CMD_STOPH = 8'h06;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_RESP} state_t;

  state_t state_reg, state_next;

  logic [CH_W-1:0]        ch_reg;
  logic [7:0]             cmd_reg;
  logic                   poll_reg;      // current read is a loop poll, not a host command
  logic [NUM_SENSORS-1:0] loop_reg;
  logic [NUM_SENSORS-1:0] mode_reg;      // 1 = humidity, 0 = temperature
  logic [TMR_W-1:0]       timer_reg;
  logic                   pending_reg;
  logic [CH_W-1:0]        rr_ptr_reg;
  logic [7:0]             rsp_cmd_reg, rsp_val_reg, rsp_addr_reg;

  // Unpack the flat sensor bus into one frame per channel.
  logic [39:0] frame [NUM_SENSORS];
  generate
    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_frame
      assign frame[gi] = sensor_data[40*gi +: 40];
    end
  endgenerate

  // ---------------------------------------------------------------- decode
  logic            accept;
  logic [CH_W-1:0] req_ch;
  logic            dec_read, dec_clr;
  logic [7:0]      dec_cmd, dec_val;

  assign accept = (state_reg == ST_IDLE) && request_valid;
  assign req_ch = request_address[CH_W-1:0];

  always_comb begin
    dec_read = 1'b0;
    dec_clr  = 1'b0;
    dec_cmd  = 8'h45;
    dec_val  = 8'h45;
    if ({1'b0, request_address} >= NUM_CH) begin
      dec_cmd = 8'hFE;
      dec_val = 8'hFE;
    end else if (loop_reg[req_ch] && request_command != CMD_STOPT &&
                 request_command != CMD_STOPH) begin
      dec_cmd = 8'hFF;
      dec_val = 8'hFF;
    end else if (request_command == CMD_STOPT) begin
      dec_clr = 1'b1;
      dec_cmd = 8'h0A;
      dec_val = 8'h0A;
    end else if (request_command == CMD_STOPH) begin
      dec_clr = 1'b1;
      dec_cmd = 8'h0B;
      dec_val = 8'h0B;
    end else begin
      case (request_command)
        CMD_CHECK, CMD_TEMP, CMD_HUM, CMD_LOOPT, CMD_LOOPH: dec_read = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------- round-robin choice
  // First set loop bit at or after rr_ptr, wrapping around.
  logic            poll_found;
  logic [CH_W-1:0] poll_ch, rr_next;
  logic            poll_start;

  always_comb begin
    poll_found = 1'b0;
    poll_ch    = '0;
    for (int k = 0; k < NUM_SENSORS; k++) begin
      if (!poll_found && loop_reg[CH_W'((int'(rr_ptr_reg) + k) % NUM_SENSORS)]) begin
        poll_found = 1'b1;
        poll_ch    = CH_W'((int'(rr_ptr_reg) + k) % NUM_SENSORS);
      end
    end
  end

  assign rr_next    = (poll_ch == CH_W'(NUM_SENSORS - 1)) ? '0 : poll_ch + 1'b1;
  assign poll_start = (state_reg == ST_IDLE) && !request_valid && pending_reg && poll_found;

  // ------------------------------------------------------- read completion
  logic [39:0] cur;
  logic [7:0]  cks, temp, hum;
  logic        done, tmo_hit, fault, read_fin;
  logic [7:0]  fin_cmd, fin_val;
  logic        fin_set, fin_mode;

  assign cur  = frame[ch_reg];
  assign cks  = cur[39:32] + cur[31:24] + cur[23:16] + cur[15:8];
  assign temp = cur[23:16];
  assign hum  = cur[39:32];
  assign done = sensor_done[ch_reg];

`ifdef SENSOR_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] tmo_reg;

  always_ff @(posedge clock) begin
    if (reset || state_reg != ST_READ) begin
      tmo_reg <= '0;
    end else if (!tmo_hit) begin
      tmo_reg <= tmo_reg + 1'b1;
    end
  end

  assign tmo_hit = (state_reg == ST_READ) && (tmo_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  assign read_fin = (state_reg == ST_READ) && (done || tmo_hit);
  // A frame that arrives on the timeout cycle still counts as arrived.
  assign fault    = sensor_error[ch_reg] | (cks != cur[7:0]) | (tmo_hit & ~done);

  always_comb begin
    fin_cmd  = 8'h1F;
    fin_val  = 8'h1F;
    fin_set  = 1'b0;
    fin_mode = 1'b0;
    if (!fault) begin
      if (poll_reg) begin
        fin_cmd = mode_reg[ch_reg] ? 8'h0E : 8'h0D;
        fin_val = mode_reg[ch_reg] ? hum : temp;
      end else begin
        case (cmd_reg)
          CMD_CHECK: begin fin_cmd = 8'h07; fin_val = 8'h07; end
          CMD_TEMP:  begin fin_cmd = 8'h09; fin_val = temp; end
          CMD_HUM:   begin fin_cmd = 8'h08; fin_val = hum; end
          CMD_LOOPT: begin fin_cmd = 8'h0D; fin_val = temp; fin_set = 1'b1; end
          CMD_LOOPH: begin fin_cmd = 8'h0E; fin_val = hum; fin_set = 1'b1; fin_mode = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = dec_read ? ST_READ : ST_RESP;
        end else if (poll_start) begin
          state_next = ST_READ;
        end
      end
      ST_READ: if (read_fin) state_next = ST_RESP;
      ST_RESP: if (response_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    request_ready  = (state_reg == ST_IDLE);
    response_valid = (state_reg == ST_RESP);
    sensor_enable  = '0;
    if (state_reg == ST_READ) begin
      sensor_enable[ch_reg] = 1'b1;
    end
  end

  assign response_command = rsp_cmd_reg;
  assign response_value   = rsp_val_reg;
  assign response_address = rsp_addr_reg;
  assign loop_active      = loop_reg;

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      ch_reg       <= '0;
      cmd_reg      <= '0;
      poll_reg     <= 1'b0;
      loop_reg     <= '0;
      mode_reg     <= '0;
      timer_reg    <= '0;
      pending_reg  <= 1'b0;
      rr_ptr_reg   <= '0;
      rsp_cmd_reg  <= '0;
      rsp_val_reg  <= '0;
      rsp_addr_reg <= '0;
    end else begin
      if (accept) begin
        ch_reg       <= req_ch;
        cmd_reg      <= request_command;
        poll_reg     <= 1'b0;
        rsp_addr_reg <= request_address;
        if (!dec_read) begin
          rsp_cmd_reg <= dec_cmd;
          rsp_val_reg <= dec_val;
        end
        if (dec_clr) begin
          loop_reg[req_ch] <= 1'b0;
        end
      end else if (poll_start) begin
        ch_reg       <= poll_ch;
        poll_reg     <= 1'b1;
        rr_ptr_reg   <= rr_next;
        rsp_addr_reg <= 8'(poll_ch);
      end

      if (read_fin) begin
        rsp_cmd_reg <= fin_cmd;
        rsp_val_reg <= fin_val;
        if (fin_set) begin
          loop_reg[ch_reg] <= 1'b1;
          mode_reg[ch_reg] <= fin_mode;
        end
      end

      // Poll timer: idle and cleared while no channel loops; a tick arriving
      // together with a poll start re-arms the pending flag.
      if (loop_reg == '0) begin
        timer_reg   <= '0;
        pending_reg <= 1'b0;
      end else if (timer_reg == TMR_W'(LOOP_PERIOD - 1)) begin
        timer_reg   <= '0;
        pending_reg <= 1'b1;
      end else begin
        timer_reg <= timer_reg + 1'b1;
        if (poll_start) begin
          pending_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_hub_controller.sv
// -----------------------------------------------------------------------------
// tb_sensor_hub_controller
//   Directed bench for sensor_hub_controller (4 channels, short loop period).
//   Expected responses are queued when stimulus is driven and compared when
//   the DUT hands a response over. A small sensor responder raises done a few
//   cycles after sensor_enable unless the channel is told to hang.
// -----------------------------------------------------------------------------
module tb_sensor_hub_controller;

  localparam int N  = 4;
  localparam int LP = 200;

  logic           clock;
  logic           reset;
  logic           request_valid;
  logic           request_ready;
  logic [7:0]     request_command;
  logic [7:0]     request_address;
  logic [N-1:0]   sensor_enable;
  logic [40*N-1:0] sensor_data;
  logic [N-1:0]   sensor_done;
  logic [N-1:0]   sensor_error;
  logic           response_valid;
  logic           response_ready;
  logic [7:0]     response_command;
  logic [7:0]     response_value;
  logic [7:0]     response_address;
  logic [N-1:0]   loop_active;

  logic [39:0]    frame_cfg [N];
  logic [N-1:0]   hang;
  logic [23:0]    sb [$];
  int             total = 0;
  int             bad = 0;
  int             resp_count = 0;

  sensor_hub_controller #(
    .NUM_SENSORS(N),
    .LOOP_PERIOD(LP)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .request_valid    (request_valid),
    .request_ready    (request_ready),
    .request_command  (request_command),
    .request_address  (request_address),
    .sensor_enable    (sensor_enable),
    .sensor_data      (sensor_data),
    .sensor_done      (sensor_done),
    .sensor_error     (sensor_error),
    .response_valid   (response_valid),
    .response_ready   (response_ready),
    .response_command (response_command),
    .response_value   (response_value),
    .response_address (response_address),
    .loop_active      (loop_active)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_data
    assign sensor_data[40*gi +: 40] = frame_cfg[gi];
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input logic [7:0] c, input logic [7:0] v, input logic [7:0] a);
    sb.push_back({c, v, a});
  endtask

  // Sensor responder: done rises on the third falling edge with enable high.
  initial begin
    int cnt [N];
    for (int i = 0; i < N; i++) cnt[i] = 0;
    sensor_done = '0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (sensor_enable[i] && !hang[i]) begin
          if (cnt[i] == 2) sensor_done[i] = 1'b1;
          else cnt[i]++;
        end else begin
          cnt[i] = 0;
          sensor_done[i] = 1'b0;
        end
      end
    end
  end

  // Response monitor: a handshake completes on the next rising edge.
  initial begin
    logic [23:0] exp_rsp;
    forever begin
      @(negedge clock);
      if (response_valid && response_ready && !reset) begin
        resp_count++;
        $display("rsp cmd=%h val=%h addr=%h", response_command, response_value, response_address);
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL rsp_unexpected: observed %h expected none",
                 {response_command, response_value, response_address});
        end
        if (sb.size() > 0) begin
          exp_rsp = sb.pop_front();
          chk("rsp", 32'({response_command, response_value, response_address}), 32'(exp_rsp));
        end
      end
    end
  end

  task automatic send(input logic [7:0] cmd, input logic [7:0] addr);
    int n = 0;
    request_valid   = 1'b1;
    request_command = cmd;
    request_address = addr;
    while (!request_ready && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    chk("req_accept", 32'(request_ready), 32'd1);
    @(posedge clock); #1;
    request_valid = 1'b0;
    $display("req cmd=%h addr=%h", cmd, addr);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || !request_ready) && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int base;
    reset           = 1'b1;
    request_valid   = 1'b0;
    request_command = '0;
    request_address = '0;
    response_ready  = 1'b1;
    sensor_error    = '0;
    hang            = '0;
    frame_cfg[0] = 40'h10_00_20_00_30;
    frame_cfg[1] = 40'h40_00_15_00_55;
    frame_cfg[2] = 40'h32_00_19_00_4B;
    frame_cfg[3] = 40'h22_00_11_00_33;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", 32'(request_ready), 32'd1);
    chk("rst_rsp_valid", 32'(response_valid), 32'd0);
    chk("rst_enable", 32'(sensor_enable), 32'd0);
    chk("rst_loop", 32'(loop_active), 32'd0);
    chk("rst_rsp_data", 32'({response_command, response_value, response_address}), 32'd0);
    reset = 1'b0;

    // Test 1: plain temperature read on channel 2.
    expect_rsp(8'h09, 8'h19, 8'h02);
    send(8'h01, 8'h02);
    chk("t1_enable", 32'(sensor_enable), 32'b0100);
    drain(100);

    // Test 2: humidity loop on channel 1, two polls per two periods, then stop.
    expect_rsp(8'h0E, 8'h40, 8'h01);
    send(8'h04, 8'h01);
    drain(100);
    chk("t2_loop_on", 32'(loop_active), 32'b0010);
    base = resp_count;
    expect_rsp(8'h0E, 8'h40, 8'h01);
    expect_rsp(8'h0E, 8'h40, 8'h01);
    repeat (2 * LP + 20) @(posedge clock);
    #1;
    chk("t2_polls", 32'(resp_count - base), 32'd2);
    chk("t2_sb", 32'(sb.size()), 32'd0);
    expect_rsp(8'hFF, 8'hFF, 8'h01);
    send(8'h01, 8'h01);
    drain(100);
    expect_rsp(8'h0B, 8'h0B, 8'h01);
    send(8'h06, 8'h01);
    drain(100);
    chk("t2_loop_off", 32'(loop_active), 32'd0);
    base = resp_count;
    repeat (2 * LP + 20) @(posedge clock);
    #1;
    chk("t2_no_polls", 32'(resp_count - base), 32'd0);

    // Test 3 + stall: loops on ch0/ch3, tick pending while host request waits.
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    expect_rsp(8'h0D, 8'h20, 8'h00);
    send(8'h03, 8'h00);
    drain(100);
    expect_rsp(8'h0E, 8'h22, 8'h03);
    send(8'h04, 8'h03);
    drain(100);
    chk("t3_loops", 32'(loop_active), 32'b1001);
    response_ready = 1'b0;
    expect_rsp(8'h45, 8'h45, 8'h01);
    send(8'h07, 8'h01);
    expect_rsp(8'h08, 8'h40, 8'h01);
    request_valid   = 1'b1;
    request_command = 8'h02;
    request_address = 8'h01;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("stall_rsp", 32'({response_command, response_value, response_address}), 32'h454501);
      chk("stall_valid", 32'(response_valid), 32'd1);
      chk("stall_req_ready", 32'(request_ready), 32'd0);
      chk("stall_enable", 32'(sensor_enable), 32'd0);
    end
    repeat (LP) @(posedge clock);
    #1;
    expect_rsp(8'h0D, 8'h20, 8'h00);
    expect_rsp(8'h0E, 8'h22, 8'h03);
    expect_rsp(8'h0D, 8'h20, 8'h00);
    response_ready = 1'b1;
    send(8'h02, 8'h01);
    drain(3 * LP + 100);
    expect_rsp(8'h0A, 8'h0A, 8'h00);
    send(8'h05, 8'h00);
    expect_rsp(8'h0A, 8'h0A, 8'h03);
    send(8'h05, 8'h03);
    drain(100);
    chk("t3_loops_off", 32'(loop_active), 32'd0);

    // Test 4: faults and immediate answers.
    frame_cfg[2] = 40'h32_00_19_00_4C;
    expect_rsp(8'h1F, 8'h1F, 8'h02);
    send(8'hAC, 8'h02);
    expect_rsp(8'h1F, 8'h1F, 8'h02);
    send(8'h04, 8'h02);
    drain(100);
    chk("t4_no_loop", 32'(loop_active), 32'd0);
    frame_cfg[2] = 40'h32_00_19_00_4B;
    expect_rsp(8'h07, 8'h07, 8'h02);
    send(8'hAC, 8'h02);
    drain(100);
    sensor_error[1] = 1'b1;
    expect_rsp(8'h1F, 8'h1F, 8'h01);
    send(8'h02, 8'h01);
    drain(100);
    sensor_error[1] = 1'b0;
    expect_rsp(8'h45, 8'h45, 8'h00);
    send(8'h07, 8'h00);
    expect_rsp(8'hFE, 8'hFE, 8'h09);
    send(8'h01, 8'h09);
    expect_rsp(8'h0A, 8'h0A, 8'h03);
    send(8'h05, 8'h03);
    expect_rsp(8'h0B, 8'h0B, 8'h02);
    send(8'h06, 8'h02);
    drain(100);

    // Test 6: reset in the middle of a read.
    expect_rsp(8'h0D, 8'h20, 8'h00);
    send(8'h03, 8'h00);
    drain(100);
    hang[2] = 1'b1;
    send(8'h01, 8'h02);
    repeat (3) @(posedge clock);
    #1;
    chk("t6_enable_held", 32'(sensor_enable), 32'b0100);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("t6_enable", 32'(sensor_enable), 32'd0);
    chk("t6_loop", 32'(loop_active), 32'd0);
    chk("t6_req_ready", 32'(request_ready), 32'd1);
    chk("t6_rsp_valid", 32'(response_valid), 32'd0);
    reset   = 1'b0;
    hang[2] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("final_sb", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
